// File: rtl/fir_cmplx_decim.sv
// fir_cmplx_decim: complex-coefficient decimating FIR with conj mode, round-half-up, saturation and valid/ready flow control
// Ports: clock, reset (sync, active-high); in_valid/in_ready handshake with Iin/Qin samples;
//   hReal/hImag packed tap coefficients (tap k at [k*DATA_WIDTH +: DATA_WIDTH]), conj_mode negates hImag;
//   out_valid/out_ready handshake with Iout/Qout results; busy high during MAC and ROUND.
module fir_cmplx_decim #(
  parameter int TAP_COUNT = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MULT_PER_CYCLE = 1,
  parameter int DECIMATION_FACTOR = 1,
  parameter int FRAC_BITS = 10
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [DATA_WIDTH-1:0]      Iin,
  input  logic signed [DATA_WIDTH-1:0]      Qin,
  input  logic [TAP_COUNT*DATA_WIDTH-1:0]   hReal,
  input  logic [TAP_COUNT*DATA_WIDTH-1:0]   hImag,
  input  logic                              conj_mode,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [DATA_WIDTH-1:0]      Iout,
  output logic signed [DATA_WIDTH-1:0]      Qout,
  output logic                              busy
);
  localparam int W = DATA_WIDTH;
  localparam int M = MULT_PER_CYCLE;
  localparam int K = TAP_COUNT / MULT_PER_CYCLE;
  localparam int AW = 2 * W + $clog2(TAP_COUNT) + 2;
  localparam int TW = K > 1 ? $clog2(K) : 1;
  localparam int DW = $clog2(DECIMATION_FACTOR + 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC_BITS - 1);

  typedef enum logic [1:0] {COLLECT, MAC, ROUND, OUT} state_t;

  state_t state_q, state_d;
  logic [TAP_COUNT*W-1:0] di_q, di_d, dq_q, dq_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [TW-1:0] tap_q, tap_d;
  logic signed [AW-1:0] acci_q, acci_d, accq_q, accq_d;
  logic conj_q, conj_d;
  logic signed [W-1:0] iout_q, iout_d, qout_q, qout_d;
  logic ovalid_q, ovalid_d;

  logic signed [W-1:0] hr [K][M];
  logic signed [W-1:0] hi [K][M];
  logic signed [W-1:0] xi [K][M];
  logic signed [W-1:0] xq [K][M];
  logic signed [AW-1:0] lane_i [M+1];
  logic signed [AW-1:0] lane_q [M+1];

  // Regroup taps by MAC cycle so the per-cycle tap select is a plain index on tap_q.
  for (genvar t = 0; t < K; t++) begin : g_tap
    for (genvar m = 0; m < M; m++) begin : g_lane_sel
      assign hr[t][m] = hReal[(t*M+m)*W +: W];
      assign hi[t][m] = hImag[(t*M+m)*W +: W];
      assign xi[t][m] = di_q[(t*M+m)*W +: W];
      assign xq[t][m] = dq_q[(t*M+m)*W +: W];
    end
  end

  // Chain of M complex MACs feeding the next accumulator values; conj flips the sign of the hImag terms.
  assign lane_i[0] = acci_q;
  assign lane_q[0] = accq_q;
  for (genvar m = 0; m < M; m++) begin : g_lane
    logic signed [2*W-1:0] p_ri, p_iq, p_rq, p_ii;
    assign p_ri = (2*W)'(hr[tap_q][m]) * (2*W)'(xi[tap_q][m]);
    assign p_iq = (2*W)'(hi[tap_q][m]) * (2*W)'(xq[tap_q][m]);
    assign p_rq = (2*W)'(hr[tap_q][m]) * (2*W)'(xq[tap_q][m]);
    assign p_ii = (2*W)'(hi[tap_q][m]) * (2*W)'(xi[tap_q][m]);
    assign lane_i[m+1] = conj_q ? lane_i[m] + AW'(p_ri) + AW'(p_iq) : lane_i[m] + AW'(p_ri) - AW'(p_iq);
    assign lane_q[m+1] = conj_q ? lane_q[m] + AW'(p_rq) - AW'(p_ii) : lane_q[m] + AW'(p_rq) + AW'(p_ii);
  end

  function automatic logic [W-1:0] sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] s;
    s = (acc + HALF) >>> FRAC_BITS;
    return s > MAXV ? MAXV[W-1:0] : s < MINV ? MINV[W-1:0] : s[W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    di_d = di_q;
    dq_d = dq_q;
    dcnt_d = dcnt_q;
    tap_d = tap_q;
    acci_d = acci_q;
    accq_d = accq_q;
    conj_d = conj_q;
    iout_d = iout_q;
    qout_d = qout_q;
    case (state_q)
      COLLECT: if (in_valid) begin
        di_d = {di_q[(TAP_COUNT-1)*W-1:0], Iin};
        dq_d = {dq_q[(TAP_COUNT-1)*W-1:0], Qin};
        dcnt_d = dcnt_q + DW'(1);
        if (dcnt_d == DW'(DECIMATION_FACTOR)) begin
          dcnt_d = '0;
          tap_d = '0;
          acci_d = '0;
          accq_d = '0;
          conj_d = conj_mode;
          state_d = MAC;
        end
      end
      MAC: begin
        acci_d = lane_i[M];
        accq_d = lane_q[M];
        tap_d = tap_q + TW'(1);
        state_d = tap_q == TW'(K - 1) ? ROUND : MAC;
      end
      ROUND: begin
        iout_d = sat(acci_q);
        qout_d = sat(accq_q);
        state_d = OUT;
      end
      OUT: state_d = out_ready ? COLLECT : OUT;
      default: state_d = COLLECT;
    endcase
    ovalid_d = state_d == OUT;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= COLLECT;
      di_q <= '0;
      dq_q <= '0;
      dcnt_q <= '0;
      tap_q <= '0;
      acci_q <= '0;
      accq_q <= '0;
      conj_q <= 1'b0;
      iout_q <= '0;
      qout_q <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      di_q <= di_d;
      dq_q <= dq_d;
      dcnt_q <= dcnt_d;
      tap_q <= tap_d;
      acci_q <= acci_d;
      accq_q <= accq_d;
      conj_q <= conj_d;
      iout_q <= iout_d;
      qout_q <= qout_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign in_ready = state_q == COLLECT;
  assign busy = state_q == MAC || state_q == ROUND;
  assign out_valid = ovalid_q;
  assign Iout = iout_q;
  assign Qout = qout_q;
endmodule

// File: doc/fir_cmplx_decim.md
Name: fir_cmplx_decim

Overview:
Parametrised complex-coefficient decimating FIR filter for the I/Q datapath.
- Accepts I/Q samples over a valid/ready handshake into a TAP_COUNT-deep delay line.
- After every DECIMATION_FACTOR accepted samples, runs a time-multiplexed MAC pass using MULT_PER_CYCLE complex multipliers.
- Rounds and saturates the result back to DATA_WIDTH and presents it on a valid/ready output with backpressure.
- Sits between the front-end sample source and the demodulator. Adds coefficient-conjugate mode, rounding, saturation and flow control.

Parameters:
TAP_COUNT, 32, number of taps; must be a multiple of MULT_PER_CYCLE.
DATA_WIDTH, 32, signed two's-complement width of samples, coefficients and outputs.
MULT_PER_CYCLE, 1, complex taps processed per MAC cycle.
DECIMATION_FACTOR, 1, accepted input samples per output sample; must be ≥1.
FRAC_BITS, 10, coefficient fractional bits (1.0 = 2^FRAC_BITS); must be ≥1.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
Iin  in  DATA_WIDTH  input in-phase sample, signed
Qin  in  DATA_WIDTH  input quadrature sample, signed
hReal  in  TAP_COUNT*DATA_WIDTH  real coefficients; tap k at bits [k*DATA_WIDTH +: DATA_WIDTH]
hImag  in  TAP_COUNT*DATA_WIDTH  imaginary coefficients; same packing
conj_mode  in  1  1 = use conj(h), i.e. negate hImag
out_valid  out  1  Iout/Qout hold a result
out_ready  in  1  downstream accepts the result
Iout  out  DATA_WIDTH  filtered in-phase output, signed
Qout  out  DATA_WIDTH  filtered quadrature output, signed
busy  out  1  high while in MAC or ROUND state

Behaviour:
- Clocking/reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset state: COLLECT. Delay lines, decimation counter, tap counter and accumulators are cleared to 0. Iout=0, Qout=0, out_valid=0, busy=0.
- Reset wins over any handshake or MAC in the same cycle. Reset mid-MAC or mid-OUT discards the pass. in_valid is ignored while reset is high.
- States: COLLECT, MAC, ROUND, OUT.
  - in_ready = (state==COLLECT); decoded from registered state.
  - out_valid = (state==OUT); registered.
  - busy = (state==MAC or ROUND).
- COLLECT, on in_valid&&in_ready:
  - Shift delay lines: sample k moves to k+1; Iin/Qin are written at index 0 (newest). The oldest sample is discarded.
  - Increment the decimation counter.
  - When the counter reaches DECIMATION_FACTOR: reset it to 0, clear accumulators and tap counter, latch conj_mode, go to MAC.
- MAC, cycle t (t=0..K-1, K=TAP_COUNT/MULT_PER_CYCLE), for taps k=t*M..t*M+M-1:
  - accI += hr[k]*I[k] - hi[k]*Q[k]
  - accQ += hr[k]*Q[k] + hi[k]*I[k]
  - hi is negated when latched conj is set.
  - After cycle K-1, go to ROUND.
- Arithmetic:
  - Products are full 2*DATA_WIDTH signed.
  - Accumulators are 2*DATA_WIDTH+clog2(TAP_COUNT)+2 bits signed; no internal overflow is possible.
  - hReal/hImag are sampled combinationally during MAC and must be stable from MAC entry to ROUND.
- ROUND (1 cycle):
  - Each output = sat(floor((acc + 2^(FRAC_BITS-1)) / 2^FRAC_BITS)), i.e. arithmetic shift with round-half-up.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register into Iout/Qout; go to OUT.
- OUT:
  - Iout/Qout/out_valid are held stable until out_valid&&out_ready.
  - On that handshake go to COLLECT; in_ready=1 in the next cycle. Iout/Qout retain their value after the handshake.
- Latency: out_valid rises on the (K+1)th rising edge after the edge that accepted the DECIMATION_FACTORth sample.
- Throughput: no input is accepted in MAC/ROUND/OUT. Minimum period per output = DECIMATION_FACTOR + K + 2 cycles with out_ready held high.
- Boundaries:
  - Delay line starts at zero, so the first outputs reflect zero history.
  - Decimation counter wraps exactly at DECIMATION_FACTOR.
  - in_valid held high during MAC/ROUND/OUT is not consumed; upstream must hold its sample.

Test Plan:
1. Impulse, TAP=4, M=1, D=1, FRAC=10, hReal={1024,512,256,0}, hImag=0; I=1000 then three 0s (Q=0) → Iout=1000,500,250,0; Qout=0 each. out_valid rises 5 edges after each acceptance.
2. Rotation, hReal[0]=0, hImag[0]=1024, other taps 0; input I=100,Q=0 → Iout=0, Qout=100. Same with conj_mode=1 → Qout=-100.
3. Decimation D=4, TAP=8, M=2; stream 8 samples with in_valid always high → exactly 2 outputs. in_ready is low for 4 MAC cycles + 1 ROUND cycle + OUT after the 4th and 8th acceptance.
4. Round/saturate, DATA_WIDTH=16, TAP=4, hReal all 1024: four inputs of 32767 → Iout=32767; four of -32768 → -32768. With hReal[0]=1 and I=512 → Iout=1 (half rounds up). With I=511 → 0.
5. Backpressure: hold out_ready=0 for 10 cycles → out_valid stays 1, Iout/Qout are stable, in_ready=0. Pulse out_ready for 1 cycle → handshake occurs and in_ready=1 on the next cycle.
6. Reset mid-MAC, then apply test 1's impulse → out_valid=0 and outputs=0 after reset, and the impulse response matches test 1 exactly (no stale history).
